seq_pattern_gen: RTL and testbench

- Serial pattern transmitter. It is the stimulus-side counterpart of the Moore non-overlapping sequence detector.
- On command it shifts out a fixed bit pattern (default 110101), MSB first, one bit per clock, on the line that feeds the detector's x input.
- Supports repeated frames with a programmable idle gap between frames, busy/done status, and abort.
- Used as a synthesizable traffic source in front of the detector, in system-level checks and on the FPGA demo.

---
 rtl/seq_pkg.sv | 15 +
 rtl/seq_bit_shifter.sv | 46 ++++
 rtl/seq_pattern_gen.sv | 147 ++++++++++++++
 tb/tb_seq_pattern_gen.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence detector / pattern generator pair.
// One pattern definition keeps both ends of the link in agreement.
package seq_pkg;

  localparam int DEF_PAT_LEN = 6;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 6'b110101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/seq_bit_shifter.sv
// Parallel-load pattern shift register, MSB first. o_msb and o_last are
// registers, so the serial line and the frame-end flag are glitch-free.
module seq_bit_shifter #(
  parameter int                 PAT_LEN = 6,
  parameter logic [PAT_LEN-1:0] PATTERN = 6'b110101
)(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_shift,
  input  logic i_clear,
  output logic o_msb,
  output logic o_last
);

  localparam int IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

  logic [PAT_LEN-1:0] r_data;
  logic [IDX_W-1:0]   r_idx;
  logic               r_last;

  // clear beats load beats shift
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data <= '0;
      r_idx  <= '0;
      r_last <= 1'b0;
    end else if (i_clear) begin
      r_data <= '0;
      r_idx  <= '0;
      r_last <= 1'b0;
    end else if (i_load) begin
      r_data <= PATTERN;
      r_idx  <= IDX_W'(PAT_LEN - 1);
      r_last <= (PAT_LEN == 1);
    end else if (i_shift) begin
      r_data <= r_data << 1;
      r_idx  <= r_idx - IDX_W'(1);
      r_last <= (r_idx == IDX_W'(1));
    end
  end

  assign o_msb  = r_data[PAT_LEN-1];
  assign o_last = r_last;

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter feeding the sequence detector: sends rep_cnt
// frames of PATTERN, MSB first, with gap_len zero cycles between frames.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int                 REP_W   = 4,
  parameter int                 GAP_W   = 4
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [REP_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap_len,
  output logic             x,
  output logic             busy,
  output logic             frame_end,
  output logic             done
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_SEND = ST_SEND;
  localparam logic [1:0] S_GAP  = ST_GAP;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]       r_state;
  logic [REP_W-1:0] r_rep;
  logic [GAP_W-1:0] r_gap_len;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_busy;
  logic             r_done;

  logic [1:0] w_nxt_state;
  logic       w_accept;
  logic       w_load;
  logic       w_shift;
  logic       w_clear;
  logic       w_rep_dec;
  logic       w_gap_load;
  logic       w_gap_dec;
  logic       w_msb;
  logic       w_last;

  // abort is checked first in SEND/GAP so it overrides every other transition
  always_comb begin
    w_nxt_state = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_clear     = 1'b0;
    w_rep_dec   = 1'b0;
    w_gap_load  = 1'b0;
    w_gap_dec   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (rep_cnt == '0) begin
            w_nxt_state = S_DONE;
          end else begin
            w_nxt_state = S_SEND;
            w_load      = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (abort) begin
          w_nxt_state = S_IDLE;
          w_clear     = 1'b1;
        end else if (!w_last) begin
          w_shift = 1'b1;
        end else begin
          w_rep_dec = 1'b1;
          if (r_rep == REP_W'(1)) begin
            w_nxt_state = S_DONE;
            w_clear     = 1'b1;
          end else if (r_gap_len == '0) begin
            w_load = 1'b1;
          end else begin
            w_nxt_state = S_GAP;
            w_clear     = 1'b1;
            w_gap_load  = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          w_nxt_state = S_IDLE;
        end else if (r_gap_cnt <= GAP_W'(1)) begin
          w_nxt_state = S_SEND;
          w_load      = 1'b1;
        end else begin
          w_gap_dec = 1'b1;
        end
      end
      S_DONE:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_rep     <= '0;
      r_gap_len <= '0;
      r_gap_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_busy  <= (w_nxt_state == S_SEND) || (w_nxt_state == S_GAP);
      r_done  <= (w_nxt_state == S_DONE);
      if (w_accept) begin
        r_rep     <= rep_cnt;
        r_gap_len <= gap_len;
      end else if (w_rep_dec) begin
        r_rep <= r_rep - REP_W'(1);
      end
      if (w_gap_load) begin
        r_gap_cnt <= r_gap_len;
      end else if (w_gap_dec) begin
        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      end
    end
  end

  seq_bit_shifter #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_shifter (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_clear (w_clear),
    .o_msb   (w_msb),
    .o_last  (w_last)
  );

  assign x         = w_msb;
  assign frame_end = w_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: per-cycle vector table plus hand-written
// sequences for long runs and asynchronous reset; a reference detector counts frames.
module tb_seq_pattern_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] rep_cnt;
  logic [3:0] gap_len;
  logic       x;
  logic       busy;
  logic       frame_end;
  logic       done;

  int total = 0;
  int bad   = 0;
  int y_count = 0;

  localparam logic [5:0] EXP_BITS = 6'b110101;

  typedef struct {
    logic       s;
    logic       a;
    logic [3:0] r;
    logic [3:0] g;
    logic       ex;
    logic       eb;
    logic       ef;
    logic       ed;
  } vec_t;

  vec_t vecs[$];

  seq_pattern_gen dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .rep_cnt   (rep_cnt),
    .gap_len   (gap_len),
    .x         (x),
    .busy      (busy),
    .frame_end (frame_end),
    .done      (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference non-overlapping 110101 detector on x
  logic [5:0] det_hist;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      det_hist <= '0;
    end else if ({det_hist[4:0], x} == 6'b110101) begin
      det_hist <= '0;
      y_count  <= y_count + 1;
    end else begin
      det_hist <= {det_hist[4:0], x};
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic a, input logic [3:0] r, input logic [3:0] g,
                     input logic ex, input logic eb, input logic ef, input logic ed);
    vec_t v;
    v.s = s; v.a = a; v.r = r; v.g = g;
    v.ex = ex; v.eb = eb; v.ef = ef; v.ed = ed;
    vecs.push_back(v);
  endtask

  // six pattern cycles; the first one optionally carries the start request
  task automatic add_frame(input logic s, input logic [3:0] r, input logic [3:0] g);
    for (int i = 0; i < 6; i++) begin
      add((i == 0) ? s : 1'b0, 1'b0, (i == 0) ? r : 4'd0, (i == 0) ? g : 4'd0,
          EXP_BITS[5-i], 1'b1, (i == 5), 1'b0);
    end
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // drive inputs, take one edge, compare outputs of the following cycle
  task automatic step(input string nm, input vec_t v);
    start = v.s; abort = v.a; rep_cnt = v.r; gap_len = v.g;
    @(posedge clk);
    #1;
    check({nm, ".x"},         int'(x),         int'(v.ex));
    check({nm, ".busy"},      int'(busy),      int'(v.eb));
    check({nm, ".frame_end"}, int'(frame_end), int'(v.ef));
    check({nm, ".done"},      int'(done),      int'(v.ed));
  endtask

  task automatic drive_idle();
    start = 1'b0; abort = 1'b0; rep_cnt = 4'd0; gap_len = 4'd0;
  endtask

  initial begin
    vec_t v;
    int   y_base;
    int   cycles;
    int   busy_n;
    int   fe_n;
    logic done_seen;

    reset = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst.x",    int'(x),    0);
    check("rst.busy", int'(busy), 0);
    check("rst.fe",   int'(frame_end), 0);
    check("rst.done", int'(done), 0);
    reset = 1'b1;

    // idle after reset, abort in IDLE has no effect
    add_idle(3);
    add(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // single frame
    add_frame(1'b1, 4'd1, 4'd0);
    add(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add_idle(2);
    // two frames back to back
    add_frame(1'b1, 4'd2, 4'd0);
    add_frame(1'b0, 4'd0, 4'd0);
    add(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add_idle(2);
    // two frames with gap 3; start sampled during the gap is ignored
    add_frame(1'b1, 4'd2, 4'd3);
    add(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b0, 4'd5, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add_frame(1'b0, 4'd0, 4'd0);
    add(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add_idle(2);
    // rep_cnt=0: done only; start in the DONE cycle is ignored
    add(1'b1, 1'b0, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_idle(2);
    // start and abort together in IDLE: start wins
    add(1'b1, 1'b1, 4'd1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add_idle(2);
    // rep_cnt=3, abort during the 4th bit of frame 2, then a normal frame
    add_frame(1'b1, 4'd3, 4'd0);
    add(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_idle(3);
    add_frame(1'b1, 4'd1, 4'd0);
    add(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    add_idle(2);
    // abort in GAP
    add_frame(1'b1, 4'd2, 4'd3);
    add(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_idle(3);

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("v%0d", i), vecs[i]);
    end
    check("det_y_table", y_count, 9);

    // maximum repeat count with a one-cycle gap: 15*6 + 14*1 busy cycles
    y_base = y_count;
    v.s = 1'b1; v.a = 1'b0; v.r = 4'd15; v.g = 4'd1;
    v.ex = 1'b1; v.eb = 1'b1; v.ef = 1'b0; v.ed = 1'b0;
    step("max0", v);
    drive_idle();
    cycles = 1; busy_n = 1; fe_n = 0; done_seen = 1'b0;
    while (!done_seen && cycles < 300) begin
      @(posedge clk);
      #1;
      cycles++;
      if (busy) busy_n++;
      if (frame_end) fe_n++;
      if (done) done_seen = 1'b1;
    end
    check("max.done_seen",  int'(done_seen), 1);
    check("max.done_cycle", cycles, 105);
    check("max.busy_cycles", busy_n, 104);
    check("max.frame_ends", fe_n, 15);
    @(posedge clk);
    #1;
    check("max.idle_busy", int'(busy), 0);
    check("max.det_y", y_count - y_base, 15);

    // asynchronous reset mid-frame: outputs drop before any clock edge
    v.s = 1'b1; v.a = 1'b0; v.r = 4'd2; v.g = 4'd0;
    v.ex = 1'b1; v.eb = 1'b1; v.ef = 1'b0; v.ed = 1'b0;
    step("ar1", v);
    v.s = 1'b0; v.r = 4'd0;
    step("ar2", v);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst.x",    int'(x),    0);
    check("async_rst.busy", int'(busy), 0);
    check("async_rst.fe",   int'(frame_end), 0);
    check("async_rst.done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v.s = 1'b0; v.a = 1'b0; v.r = 4'd0; v.g = 4'd0;
      v.ex = 1'b0; v.eb = 1'b0; v.ef = 1'b0; v.ed = 1'b0;
      step($sformatf("post_rst%0d", i), v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
